// File: rtl/quadrature_oscillator_sync_if.sv
// quadrature_oscillator_sync_if: control, preload and state bus of the I/Q oscillator
interface quadrature_oscillator_sync_if;
    logic               load;
    logic signed [15:0] re_coeff;
    logic signed [15:0] im_coeff;
    logic signed [15:0] power;
    logic signed [15:0] accu_re_init;
    logic signed [15:0] accu_im_init;
    logic signed [15:0] accu_re;
    logic signed [15:0] accu_im;
    modport master (
        output load, re_coeff, im_coeff, power, accu_re_init, accu_im_init,
        input  accu_re, accu_im
    );
    modport slave (
        input  load, re_coeff, im_coeff, power, accu_re_init, accu_im_init,
        output accu_re, accu_im
    );
endinterface

// File: rtl/quadrature_oscillator_sync.sv
// quadrature_oscillator_sync: complex-rotation I/Q oscillator with sign-based AGC
module quadrature_oscillator_sync #(
    parameter int AGC_SHIFT = 8
) (
    input logic clk,
    input logic rst_n,
    quadrature_oscillator_sync_if.slave osc
);
    logic signed [15:0] re, im;
    logic signed [31:0] m_rc, m_ic, m_ri, m_ir, m_rr, m_ii;
    logic signed [33:0] pr, pi;
    logic signed [18:0] rr, ri;
    logic [31:0] mag2;
    logic agc_en, grow, shrink;

    assign osc.accu_re = re;
    assign osc.accu_im = im;

    assign m_rc = re * osc.re_coeff;
    assign m_ic = im * osc.im_coeff;
    assign m_ri = re * osc.im_coeff;
    assign m_ir = im * osc.re_coeff;
    assign m_rr = re * re;
    assign m_ii = im * im;

    assign pr = 34'(m_rc) - 34'(m_ic);
    assign pi = 34'(m_ri) + 34'(m_ir);
    // Round half up back to Q0; 19 bits hold the worst case |z|*|c| of about 2^16
    assign rr = 19'((pr + 34'sd16384) >>> 15);
    assign ri = 19'((pi + 34'sd16384) >>> 15);

    assign mag2   = $unsigned(m_rr) + $unsigned(m_ii);
    assign agc_en = osc.power > 16'sd0;
    assign grow   = agc_en && (mag2 < {16'd0, osc.power});
    assign shrink = agc_en && (mag2 > {16'd0, osc.power});

    function automatic logic signed [18:0] agc(input logic signed [18:0] c, input logic g, input logic s);
        logic signed [18:0] mag, step;
        mag  = (c < 0) ? -c : c;
        step = ((mag >>> AGC_SHIFT) == '0) ? 19'sd1 : (mag >>> AGC_SHIFT);
        return (c == '0) ? c :
               g ? ((c > 0) ? c + step : c - step) :
               s ? ((c > 0) ? c - step : c + step) : c;
    endfunction

    function automatic logic signed [15:0] sat(input logic signed [18:0] c);
        return (c > 19'sd32767) ? 16'sh7fff : (c < -19'sd32768) ? 16'sh8000 : c[15:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            re <= '0;
            im <= '0;
        end else if (osc.load) begin
            re <= osc.accu_re_init;
            im <= osc.accu_im_init;
        end else begin
            re <= sat(agc(rr, grow, shrink));
            im <= sat(agc(ri, grow, shrink));
        end
    end
endmodule

// File: tb/tb_quadrature_oscillator_sync.sv
// tb_quadrature_oscillator_sync: directed checks of rotation, saturation, load, reset and AGC
module tb_quadrature_oscillator_sync;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_checks = 0;
    int n_fail = 0;

    quadrature_oscillator_sync_if bus();

    quadrature_oscillator_sync dut (
        .clk(clk),
        .rst_n(rst_n),
        .osc(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setup(input logic signed [15:0] cr, input logic signed [15:0] ci, input logic signed [15:0] pw);
        bus.re_coeff = cr;
        bus.im_coeff = ci;
        bus.power = pw;
    endtask

    task automatic preload(input logic signed [15:0] r, input logic signed [15:0] i);
        bus.load = 1'b1;
        bus.accu_re_init = r;
        bus.accu_im_init = i;
        tick();
        bus.load = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (bus.accu_re !== 16'sd0 || bus.accu_im !== 16'sd0) begin
            n_fail++;
            $display("FAIL reset_initial: got (%0d,%0d) want (0,0)", bus.accu_re, bus.accu_im);
        end
        rst_n = 1'b1;
        setup(16'sh0000, 16'sh7fff, 16'sd0);
        preload(16'sd32, 16'sd0);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.accu_re !== 16'sd0 || bus.accu_im !== 16'sd0) begin
            n_fail++;
            $display("FAIL reset_async: got (%0d,%0d) want (0,0)", bus.accu_re, bus.accu_im);
        end
        tick();
        tick();
        n_checks++;
        if (bus.accu_re !== 16'sd0 || bus.accu_im !== 16'sd0) begin
            n_fail++;
            $display("FAIL reset_held: got (%0d,%0d) want (0,0)", bus.accu_re, bus.accu_im);
        end
        rst_n = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus.accu_re !== 16'sd0 || bus.accu_im !== 16'sd0) begin
            n_fail++;
            $display("FAIL zero_stays_zero: got (%0d,%0d) want (0,0)", bus.accu_re, bus.accu_im);
        end
    endtask

    task automatic test_rotation();
        logic signed [15:0] er [5] = '{16'sd32, 16'sd0, -16'sd32, 16'sd0, 16'sd32};
        logic signed [15:0] ei [5] = '{16'sd0, 16'sd32, 16'sd0, -16'sd32, 16'sd0};
        setup(16'sh0000, 16'sh7fff, 16'sd0);
        preload(16'sd32, 16'sd0);
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (bus.accu_re !== er[k] || bus.accu_im !== ei[k]) begin
                n_fail++;
                $display("FAIL rotate90_step%0d: got (%0d,%0d) want (%0d,%0d)", k, bus.accu_re, bus.accu_im, er[k], ei[k]);
            end
            tick();
        end
    endtask

    task automatic test_saturation();
        setup(16'sh7fff, 16'sh7fff, 16'sd0);
        preload(16'sh7fff, 16'sh7fff);
        tick();
        n_checks++;
        if (bus.accu_re !== 16'sd0 || bus.accu_im !== 16'sd32767) begin
            n_fail++;
            $display("FAIL sat_pos: got (%0d,%0d) want (0,32767)", bus.accu_re, bus.accu_im);
        end
        preload(16'sh8000, 16'sh8000);
        tick();
        n_checks++;
        if (bus.accu_re !== 16'sd0 || bus.accu_im !== -16'sd32768) begin
            n_fail++;
            $display("FAIL sat_neg: got (%0d,%0d) want (0,-32768)", bus.accu_re, bus.accu_im);
        end
        setup(16'sh8000, 16'sh0000, 16'sd0);
        preload(16'sh8000, 16'sd0);
        tick();
        n_checks++;
        if (bus.accu_re !== 16'sd32767 || bus.accu_im !== 16'sd0) begin
            n_fail++;
            $display("FAIL sat_negcoeff: got (%0d,%0d) want (32767,0)", bus.accu_re, bus.accu_im);
        end
    endtask

    task automatic test_load_hold();
        logic signed [15:0] vr [4] = '{16'sd100, -16'sd5, 16'sh7fff, 16'sd0};
        logic signed [15:0] vi [4] = '{-16'sd7, 16'sd1234, 16'sh8000, 16'sd9};
        setup(16'sh7d34, 16'sh1a9d, 16'sd0);
        bus.load = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.accu_re_init = vr[k];
            bus.accu_im_init = vi[k];
            tick();
            n_checks++;
            if (bus.accu_re !== vr[k] || bus.accu_im !== vi[k]) begin
                n_fail++;
                $display("FAIL load_hold%0d: got (%0d,%0d) want (%0d,%0d)", k, bus.accu_re, bus.accu_im, vr[k], vi[k]);
            end
        end
        bus.load = 1'b0;
    endtask

    task automatic test_agc_step();
        logic signed [15:0] ir [7] = '{16'sd100, 16'sd100, 16'sd1000, -16'sd1000, -16'sd100, 16'sd100, 16'sd100};
        logic signed [15:0] pw [7] = '{16'sd1, 16'sd32767, 16'sd1, 16'sd1, 16'sd32767, 16'sd10000, -16'sd32768};
        logic signed [15:0] ex [7] = '{16'sd99, 16'sd101, 16'sd997, -16'sd997, -16'sd101, 16'sd100, 16'sd100};
        for (int k = 0; k < 7; k++) begin
            setup(16'sh7fff, 16'sh0000, pw[k]);
            preload(ir[k], 16'sd0);
            tick();
            n_checks++;
            if (bus.accu_re !== ex[k] || bus.accu_im !== 16'sd0) begin
                n_fail++;
                $display("FAIL agc_step%0d: got (%0d,%0d) want (%0d,0)", k, bus.accu_re, bus.accu_im, ex[k]);
            end
        end
    endtask

    task automatic test_agc_long(input logic signed [15:0] pw, input int settle, input int lo, input int hi, input bit chk_period);
        int m2, xings, bad;
        logic signed [15:0] prev_im;
        setup(16'sh7d34, 16'sh1a9d, pw);
        preload(16'sd32, 16'sd0);
        xings = 0;
        bad = 0;
        prev_im = bus.accu_im;
        for (int c = 1; c <= 1000; c++) begin
            tick();
            m2 = int'(bus.accu_re) * int'(bus.accu_re) + int'(bus.accu_im) * int'(bus.accu_im);
            if (c > settle) begin
                n_checks++;
                if (m2 < lo || m2 > hi) begin
                    n_fail++;
                    bad++;
                    if (bad <= 5)
                        $display("FAIL agc_mag2_p%0d_c%0d: got %0d want [%0d,%0d]", pw, c, m2, lo, hi);
                end
            end
            if (c > 200 && c <= 800 && prev_im < 0 && bus.accu_im >= 0)
                xings++;
            prev_im = bus.accu_im;
        end
        if (chk_period) begin
            n_checks++;
            if (xings < 18 || xings > 22) begin
                n_fail++;
                $display("FAIL period_crossings: got %0d want [18,22] in 600 cycles", xings);
            end
        end
    endtask

    initial begin
        bus.load = 1'b0;
        bus.re_coeff = '0;
        bus.im_coeff = '0;
        bus.power = '0;
        bus.accu_re_init = '0;
        bus.accu_im_init = '0;
        #12;
        test_reset();
        test_rotation();
        test_saturation();
        test_load_hold();
        test_agc_step();
        test_agc_long(16'sh0400, 200, 700, 1400, 1'b1);
        test_agc_long(16'sh0100, 300, 150, 400, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
